// File: rtl/uart_seq_checker.sv
// uart_seq_checker
//   Receive-side checker for an incrementing-byte (+1 mod 256) UART test
//   stream. It locks onto the sequence, then counts good bytes, sequence
//   errors, framing errors and link timeouts for LED / debug readout.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   datain[7:0]  received byte, valid when rdsig=1
//   rdsig        byte strobe, one byte per high cycle
//   frame_err    framing error, qualified by rdsig
//   clr          synchronous clear of counters and the sticky flag
//   locked       sequence lock indicator
//   err_pulse    one-cycle pulse per sequence or framing error
//   timeout      one-cycle pulse when the link goes quiet too long
//   err_cnt      saturating error count
//   byte_cnt     wrapping good-frame count
//   last_byte    most recent good-frame byte
//   lost_sticky  set by a timeout or by any error while locked
module uart_seq_checker #(
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TO_W           = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  datain,
    input  logic        rdsig,
    input  logic        frame_err,
    input  logic        clr,
    output logic        locked,
    output logic        err_pulse,
    output logic        timeout,
    output logic [15:0] err_cnt,
    output logic [31:0] byte_cnt,
    output logic [7:0]  last_byte,
    output logic        lost_sticky
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      exp_q, exp_d;
    logic [3:0]      match_q, match_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            good, bad, seq_err, tmo, err_ev;

    assign good   = rdsig & ~frame_err;
    assign bad    = rdsig & frame_err;
    assign err_ev = bad | seq_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= 8'd0;
            match_q <= 4'd0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        match_d = match_q;
        to_d    = to_q;
        seq_err = 1'b0;
        tmo     = 1'b0;

        if (bad) begin
            // Framing errors always drop back to acquisition; exp is kept so
            // the stream can resume where it left off.
            state_d = SYNC;
            match_d = 4'd0;
            to_d    = '0;
        end else if (good) begin
            to_d  = '0;
            exp_d = datain + 8'd1;
            unique case (state_q)
                IDLE: begin
                    match_d = 4'd1;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (datain == exp_q) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == 4'(LOCK_COUNT))
                            state_d = LOCKED;
                    end else begin
                        // Restart the run from this byte; not an error yet.
                        match_d = 4'd1;
                    end
                end
                LOCKED: begin
                    // A mismatch reseeds exp and keeps lock.
                    if (datain != exp_q)
                        seq_err = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A byte arriving on the final count wins, so the timeout is
            // only evaluated in cycles without rdsig.
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo     = 1'b1;
                state_d = IDLE;
                match_d = 4'd0;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= 16'd0;
            byte_cnt    <= 32'd0;
            last_byte   <= 8'd0;
            lost_sticky <= 1'b0;
        end else begin
            locked    <= (state_d == LOCKED);
            err_pulse <= err_ev;
            timeout   <= tmo;
            if (good)
                last_byte <= datain;
            // clr overrides any event landing in the same cycle.
            if (clr) begin
                err_cnt     <= 16'd0;
                byte_cnt    <= 32'd0;
                lost_sticky <= 1'b0;
            end else begin
                if (err_ev && err_cnt != 16'hFFFF)
                    err_cnt <= err_cnt + 16'd1;
                if (good)
                    byte_cnt <= byte_cnt + 32'd1;
                if (tmo || (err_ev && state_q == LOCKED))
                    lost_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_seq_checker.sv
// Self-checking bench for uart_seq_checker with a behavioural model that
// tracks the stream in terms of run length, expected byte and idle time.
module tb_uart_seq_checker;

    localparam int LOCK_COUNT = 4;
    localparam int TMO        = 1000;
    localparam int TO_W       = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  datain = 8'd0;
    logic        rdsig = 1'b0;
    logic        frame_err = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err_pulse, timeout, lost_sticky;
    logic [15:0] err_cnt;
    logic [31:0] byte_cnt;
    logic [7:0]  last_byte;

    uart_seq_checker #(
        .LOCK_COUNT     (LOCK_COUNT),
        .TIMEOUT_CYCLES (TMO),
        .TO_W           (TO_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .datain      (datain),
        .rdsig       (rdsig),
        .frame_err   (frame_err),
        .clr         (clr),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .timeout     (timeout),
        .err_cnt     (err_cnt),
        .byte_cnt    (byte_cnt),
        .last_byte   (last_byte),
        .lost_sticky (lost_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit quiet    = 1'b0;

    // Reference model state
    bit          m_active;   // a byte has been seen since reset/timeout
    bit          m_lock;
    int          m_run;      // length of current in-sequence run
    int          m_exp;
    int          m_idle;
    bit          m_err, m_tmo, m_lost;
    int          m_errs;
    logic [31:0] m_bytes;
    int          m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, want, $time);
    endtask

    task automatic m_reset();
        m_active = 0; m_lock = 0; m_run = 0; m_exp = 0; m_idle = 0;
        m_err = 0; m_tmo = 0; m_lost = 0; m_errs = 0; m_bytes = 0; m_last = 0;
    endtask

    task automatic m_step(input bit rd, input int d, input bit fe, input bit c);
        m_err = 0;
        m_tmo = 0;
        if (rd && fe) begin
            m_err = 1;
            if (m_lock) m_lost = 1;
            m_lock = 0; m_run = 0; m_active = 1; m_idle = 0;
        end else if (rd) begin
            m_idle = 0;
            if (!m_active) begin
                m_active = 1; m_run = 1;
            end else if (!m_lock) begin
                m_run = (d == m_exp) ? m_run + 1 : 1;
                if (m_run >= LOCK_COUNT) m_lock = 1;
            end else if (d != m_exp) begin
                m_err = 1; m_lost = 1;
            end
            m_exp = (d + 1) % 256;
            m_bytes = m_bytes + 1;
            m_last = d;
        end else if (m_active) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_tmo = 1; m_lock = 0; m_lost = 1; m_active = 0; m_idle = 0; m_run = 0;
            end
        end
        if (m_err && m_errs < 65535) m_errs++;
        if (c) begin
            m_errs = 0; m_bytes = 0; m_lost = 0;
        end
    endtask

    task automatic compare_all();
        check("locked",      32'(locked),      32'(m_lock));
        check("err_pulse",   32'(err_pulse),   32'(m_err));
        check("timeout",     32'(timeout),     32'(m_tmo));
        check("err_cnt",     32'(err_cnt),     32'(m_errs));
        check("byte_cnt",    byte_cnt,         m_bytes);
        check("last_byte",   32'(last_byte),   32'(m_last));
        check("lost_sticky", 32'(lost_sticky), 32'(m_lost));
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled #1 after the next one.
    task automatic step(input bit rd, input int d, input bit fe, input bit c);
        rdsig = rd; datain = 8'(d); frame_err = fe; clr = c;
        m_step(rd, d, fe, c);
        @(posedge clk);
        #1;
        if (!quiet) compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_zero"}, {locked, err_pulse, timeout, lost_sticky, err_cnt, last_byte}, 32'd0);
        check({tag, "_bytes_zero"}, byte_cnt, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int seq;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Acquire lock on 0x10..0x13 with 255-cycle spacing
        for (int b = 0; b < 4; b++) begin
            step(1, 8'h10 + b, 0, 0);
            if (b == 2) check("no_lock_after_3", 32'(locked), 32'd0);
            if (b < 3) idle(254);
        end
        check("lock_after_4", 32'(locked), 32'd1);
        check("bytes_after_4", byte_cnt, 32'd4);
        check("errs_after_4", 32'(err_cnt), 32'd0);
        check("last_after_4", 32'(last_byte), 32'h13);
        idle(254);

        // Run up through the 0xFF -> 0x00 wrap
        for (int b = 8'h14; b <= 8'hFD; b++) step(1, b, 0, 0);
        for (int b = 0; b < 4; b++) step(1, (8'hFE + b) % 256, 0, 0);
        check("wrap_errs", 32'(err_cnt), 32'd0);
        check("wrap_locked", 32'(locked), 32'd1);
        check("wrap_bytes", byte_cnt, 32'd4 + 32'd234 + 32'd4);

        // Mismatch while locked reseeds and keeps lock
        for (int b = 2; b <= 8'h20; b++) step(1, b, 0, 0);
        step(1, 8'h25, 0, 0);
        check("mm_pulse", 32'(err_pulse), 32'd1);
        check("mm_errs", 32'(err_cnt), 32'd1);
        check("mm_lost", 32'(lost_sticky), 32'd1);
        step(1, 8'h26, 0, 0);
        check("mm_reseed_pulse", 32'(err_pulse), 32'd0);
        check("mm_reseed_last", 32'(last_byte), 32'h26);
        check("mm_reseed_locked", 32'(locked), 32'd1);

        // rdsig on the final idle count beats the timeout
        idle(TMO - 1);
        step(1, 8'h27, 0, 0);
        check("edge_no_timeout", 32'(timeout), 32'd0);
        check("edge_locked", 32'(locked), 32'd1);
        idle(TMO - 1);
        check("pre_timeout", 32'(timeout), 32'd0);
        idle(1);
        check("timeout_pulse", 32'(timeout), 32'd1);
        check("timeout_unlock", 32'(locked), 32'd0);
        check("timeout_lost", 32'(lost_sticky), 32'd1);
        idle(1);
        check("timeout_one_cycle", 32'(timeout), 32'd0);
        for (int b = 0; b < 4; b++) step(1, 8'h50 + b, 0, 0);
        check("relock_after_timeout", 32'(locked), 32'd1);

        // Framing error while locked
        step(0, 0, 0, 1);
        step(1, 8'h54, 1, 0);
        check("fe_errs", 32'(err_cnt), 32'd1);
        check("fe_bytes", byte_cnt, 32'd0);
        check("fe_unlock", 32'(locked), 32'd0);
        check("fe_lost", 32'(lost_sticky), 32'd1);
        for (int b = 0; b < LOCK_COUNT; b++) step(1, 8'h54 + b, 0, 0);
        check("fe_relock", 32'(locked), 32'd1);

        // Saturate the error counter with back-to-back mismatches
        d = 8'h60;
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            step(1, d, 0, 0);
            d = (d + 2) % 256;
        end
        quiet = 1'b0;
        compare_all();
        check("sat_errs", 32'(err_cnt), 32'hFFFF);
        step(1, d, 0, 0);
        check("sat_hold", 32'(err_cnt), 32'hFFFF);
        check("sat_pulse", 32'(err_pulse), 32'd1);
        d = (d + 2) % 256;
        step(1, d, 0, 1);
        check("clr_mm_errs", 32'(err_cnt), 32'd0);
        check("clr_mm_pulse", 32'(err_pulse), 32'd1);
        check("clr_mm_bytes", byte_cnt, 32'd0);

        // Asynchronous reset mid-SYNC
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all_zero("rst_locked");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 8'h33, 0, 0);
        check("sync_bytes", byte_cnt, 32'd1);
        step(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all_zero("rst_sync");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        // Randomised traffic with occasional long gaps
        seq = $urandom_range(0, 255);
        for (int i = 0; i < 4000; i++) begin
            bit rd, fe, c;
            if (i == 1500 || i == 3000) idle($urandom_range(TMO - 10, TMO + 10));
            rd = ($urandom_range(0, 3) == 0);
            fe = rd && ($urandom_range(0, 19) == 0);
            c  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) seq = $urandom_range(0, 255);
            step(rd, seq, fe, c);
            if (rd && !fe) seq = (seq + 1) % 256;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_seq_checker.md
Name: uart_seq_checker

Overview:
- Receive-side counterpart of the incrementing-byte UART test generator.
- Sits behind the UART receiver and consumes its byte strobe (datain/rdsig).
- Locks onto the +1 (mod 256) byte sequence and counts good bytes, sequence errors, framing errors and link timeouts.
- Drives LEDs / debug readout for loopback and board-to-board link tests.

Parameters:
- LOCK_COUNT, 4: consecutive in-sequence bytes required to declare lock (range 2..15).
- TIMEOUT_CYCLES, 50000000: clk cycles without rdsig before the link is declared lost (1 s at 50 MHz).
- TO_W, 26: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- datain  input  8  received byte, valid when rdsig=1.
- rdsig  input  1  byte-valid strobe from receiver; every high cycle is one byte.
- frame_err  input  1  receiver framing error, qualified by rdsig.
- clr  input  1  synchronous clear of counters and sticky flags.
- locked  output  1  sequence lock indicator.
- err_pulse  output  1  one-cycle pulse per sequence or framing error.
- timeout  output  1  one-cycle pulse on link timeout.
- err_cnt  output  16  error count, saturating at 0xFFFF.
- byte_cnt  output  32  good-frame count, wraps.
- last_byte  output  8  most recent good-frame byte.
- lost_sticky  output  1  set by a timeout, or by any error while locked; cleared by clr.

Behaviour:
- Reset: all outputs 0; state IDLE; expected byte exp=0; match_cnt=0; timeout counter=0.
- All outputs are registered. locked, err_pulse, timeout and the counters update in the cycle after the causing rdsig edge (latency 1).
- Good frame: rdsig=1 and frame_err=0.
  - byte_cnt += 1; last_byte <= datain; timeout counter <= 0.
- Bad frame: rdsig=1 and frame_err=1.
  - Byte discarded; byte_cnt and last_byte unchanged; timeout counter <= 0.
  - err_pulse=1; err_cnt += 1 (saturating).
  - If LOCKED: lost_sticky=1; go to SYNC with match_cnt=0.
  - In IDLE or SYNC: stay in / enter SYNC with match_cnt=0.
- IDLE:
  - Good frame: exp <= datain+1 (8-bit wrap), match_cnt <= 1, go to SYNC.
- SYNC:
  - Good frame with datain==exp: exp <= datain+1; match_cnt += 1. When match_cnt reaches LOCK_COUNT, go to LOCKED and assert locked.
  - Good frame with datain!=exp: exp <= datain+1; match_cnt <= 1; no error counted.
- LOCKED:
  - Good frame with datain==exp: exp <= datain+1.
  - Good frame with datain!=exp: err_pulse=1; err_cnt += 1; lost_sticky=1; exp <= datain+1 (reseed); stay LOCKED.
- Wrap-around: 0xFF followed by 0x00 is in sequence, never an error.
- Timeout counter:
  - Runs only in SYNC and LOCKED; held at 0 in IDLE.
  - Increments every cycle without rdsig.
  - On reaching TIMEOUT_CYCLES: timeout=1 for one cycle, locked=0, lost_sticky=1, state IDLE, counter 0, match_cnt 0.
  - An rdsig in the same cycle the count would reach TIMEOUT_CYCLES wins: the byte is processed and there is no timeout.
- clr:
  - Zeroes err_cnt, byte_cnt and lost_sticky; does not change state, exp, locked or last_byte.
  - clr coincident with a counting event: clr wins, that event is not counted; err_pulse still fires.
- err_cnt holds at 0xFFFF; further errors still pulse err_pulse.
- Reset mid-operation (any state) returns immediately to reset values; no pulse is emitted on reset release.

Test Plan:
- Reset, then bytes 0x10,0x11,0x12,0x13 with 255-cycle spacing -> locked=1 one cycle after the 4th rdsig; byte_cnt=4; err_cnt=0; last_byte=0x13.
- While locked, send 0xFE,0xFF,0x00,0x01 -> no err_pulse; err_cnt=0; locked stays 1; byte_cnt +4.
- Locked with exp=0x21, send 0x25 then 0x26 -> one err_pulse; err_cnt=1; lost_sticky=1; 0x26 accepted; locked stays 1.
- Bench with TIMEOUT_CYCLES=1000: lock, then idle rdsig -> timeout pulse after 1000 cycles; locked=0; lost_sticky=1. Next 4 sequential bytes re-lock. rdsig exactly at cycle 1000 -> no timeout.
- rdsig with frame_err=1 while locked -> err_cnt +1; byte_cnt unchanged; locked=0; LOCK_COUNT good bytes re-lock.
- Force 65540 mismatches -> err_cnt stays 0xFFFF. clr coincident with a mismatch -> err_cnt=0 and err_pulse=1. Assert rst_n=0 mid-SYNC -> all outputs 0 immediately.
